// File: rtl/io_uart_pkg.sv
// Shared definitions for the io_uart_tx_port slice: FSM state encoding, io_in status
// bit positions and frame lengths. Optional feature macro: IO_UART_PARITY_EN (8E1 frames).
package io_uart_pkg;

`ifdef IO_UART_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} tx_state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} tx_state_e;
`endif

    // io_in status word layout; bits [9:0] always read as zero.
    localparam int unsigned IO_IN_BUSY      = 15;
    localparam int unsigned IO_IN_FULL      = 14;
    localparam int unsigned IO_IN_OVERFLOW  = 13;
    localparam int unsigned IO_IN_COUNT_LSB = 10;
    localparam int unsigned IO_IN_COUNT_W   = 3;

    // Bit times per serial byte: start + 8 data (+ parity) + stop.
    localparam int unsigned BITS_PER_FRAME_8N1 = 10;
    localparam int unsigned BITS_PER_FRAME_8E1 = 11;

`ifdef IO_UART_PARITY_EN
    localparam int unsigned BITS_PER_FRAME = BITS_PER_FRAME_8E1;
`else
    localparam int unsigned BITS_PER_FRAME = BITS_PER_FRAME_8N1;
`endif

endpackage

// File: rtl/io_uart_tx_port_uart_tx_byte.sv
// uart_tx_byte: serialises one byte as START / 8 data LSB-first / [PARITY] / STOP.
// Accepts a new byte in IDLE, or on the last STOP cycle so bytes can run back-to-back.
// Optional feature macro: IO_UART_PARITY_EN adds an even-parity bit (8E1).
module uart_tx_byte
    import io_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       idle,
    output logic       tx
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_done;
`ifdef IO_UART_PARITY_EN
    logic          parity;
`endif

    assign bit_done = (cnt == '0);
    assign idle     = (state == StIdle);
    assign ready    = idle || ((state == StStop) && bit_done);

    // Frame sequencer; tx is registered so the line changes only on clock edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            tx      <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef IO_UART_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (valid) begin
                        state  <= StStart;
                        tx     <= 1'b0;
                        cnt    <= CNT_MAX;
                        shreg  <= data;
`ifdef IO_UART_PARITY_EN
                        parity <= ^data;
`endif
                    end
                end
                StStart: begin
                    if (bit_done) begin
                        state   <= StData;
                        tx      <= shreg[0];
                        cnt     <= CNT_MAX;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                StData: begin
                    if (bit_done) begin
                        cnt <= CNT_MAX;
                        if (bit_idx == 3'd7) begin
`ifdef IO_UART_PARITY_EN
                            state <= StParity;
                            tx    <= parity;
`else
                            state <= StStop;
                            tx    <= 1'b1;
`endif
                        end else begin
                            // tx already shows shreg[0]; shift and present the next bit.
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
`ifdef IO_UART_PARITY_EN
                StParity: begin
                    if (bit_done) begin
                        state <= StStop;
                        tx    <= 1'b1;
                        cnt   <= CNT_MAX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
`endif
                StStop: begin
                    if (bit_done) begin
                        if (valid) begin
                            state  <= StStart;
                            tx     <= 1'b0;
                            cnt    <= CNT_MAX;
                            shreg  <= data;
`ifdef IO_UART_PARITY_EN
                            parity <= ^data;
`endif
                        end else begin
                            state <= StIdle;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/io_uart_tx_port.sv
// io_uart_tx_port: every change on io_out is queued and sent over UART, low byte first.
// io_in returns {busy, full, overflow, count[2:0], 10'b0}, registered.
// Optional feature macro: IO_UART_PARITY_EN (8E1 frames instead of 8N1).
module io_uart_tx_port
    import io_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] io_out,
    output logic [15:0] io_in,
    output logic        tx
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [IO_IN_COUNT_W-1:0] CNT_FULL = IO_IN_COUNT_W'(FIFO_DEPTH);

    logic [15:0]              last;
    logic [15:0]              mem [FIFO_DEPTH];
    logic [PW-1:0]            rd_ptr;
    logic [PW-1:0]            wr_ptr;
    logic [IO_IN_COUNT_W-1:0] count;
    logic                     overflow;
    logic [7:0]               hi_byte;
    logic                     hi_pending;  // low byte sent, high byte still owed

    logic       push_req;
    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic       fifo_full;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_idle;
    logic [7:0] tx_data;
    logic       busy;
    logic [15:0] status;

    assign push_req   = (io_out != last);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    // A new word is only taken from the FIFO while the shifter idles, giving one idle
    // cycle between words; the high byte follows the low byte with no gap.
    assign tx_valid   = hi_pending || (!fifo_empty && tx_idle);
    assign tx_data    = hi_pending ? hi_byte : mem[rd_ptr][7:0];
    assign pop        = tx_valid && tx_ready && !hi_pending;
    assign push       = push_req && (!fifo_full || pop);
    assign busy       = !fifo_empty || !tx_idle;

    // Write detection: remember the last io_out value seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= '0;
        end else if (push_req) begin
            last <= io_out;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= io_out;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + IO_IN_COUNT_W'(1);
            end else if (pop && !push) begin
                count <= count - IO_IN_COUNT_W'(1);
            end
            if (push_req && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Two-byte sequencing: capture the high byte when the low byte is handed over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_pending <= 1'b0;
            hi_byte    <= '0;
        end else if (tx_valid && tx_ready) begin
            if (hi_pending) begin
                hi_pending <= 1'b0;
            end else begin
                hi_pending <= 1'b1;
                hi_byte    <= mem[rd_ptr][15:8];
            end
        end
    end

    // Assemble the status word from current state.
    always_comb begin
        status = '0;
        status[IO_IN_BUSY] = busy;
        status[IO_IN_FULL] = fifo_full;
        status[IO_IN_OVERFLOW] = overflow;
        status[IO_IN_COUNT_LSB +: IO_IN_COUNT_W] = count;
    end

    // Registered status, one cycle behind the FIFO/FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_in <= '0;
        end else begin
            io_in <= status;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk  (clk),
        .reset(reset),
        .data (tx_data),
        .valid(tx_valid),
        .ready(tx_ready),
        .idle (tx_idle),
        .tx   (tx)
    );

endmodule

// File: tb/tb_io_uart_tx_port.sv
// Bench for io_uart_tx_port at CLKS_PER_BIT=4. Expected bytes are queued when words are
// written and popped by a serial-line decoder. Honours IO_UART_PARITY_EN when defined.
module tb_io_uart_tx_port;

    localparam int unsigned CPB = 4;
`ifdef IO_UART_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned WORD_CYC = 2 * FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] io_out = '0;
    logic [15:0] io_in;
    logic        tx;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    io_uart_tx_port #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io_out(io_out),
        .io_in (io_in),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_word(input logic [15:0] w);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        io_out = '0;
        exp_q.delete();
        tick(3);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic wait_drain(input string name, input int unsigned budget);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || io_in[15] !== 1'b0) && n < budget) begin
            tick(1);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0 || io_in[15] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d bytes outstanding busy=%b, want 0 bytes busy=0",
                     name, exp_q.size(), io_in[15]);
        end
    endtask

    // Serial decoder: samples at +3 after each edge, mid-bit, and scores each byte.
    task automatic mon_wait(input int unsigned n, inout bit aborted);
        repeat (n) begin
            @(posedge clk);
            #3;
            if (reset) aborted = 1'b1;
        end
    endtask

    initial begin : monitor
        logic [7:0] got;
        logic [7:0] want;
        logic       stop_bit;
        logic       par_bit;
        bit         ab;
        forever begin
            @(posedge clk);
            #3;
            if (!reset && tx === 1'b0) begin
                ab = 1'b0;
                got = '0;
                par_bit = 1'b0;
                mon_wait(CPB + CPB / 2, ab);
                got[0] = tx;
                for (int i = 1; i < 8; i++) begin
                    mon_wait(CPB, ab);
                    got[i] = tx;
                end
`ifdef IO_UART_PARITY_EN
                mon_wait(CPB, ab);
                par_bit = tx;
`endif
                mon_wait(CPB, ab);
                stop_bit = tx;
                if (!ab) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL line_byte: got unexpected byte %02h, want none", got);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want || stop_bit !== 1'b1) begin
                            miscompares++;
                            $display("FAIL line_byte: got %02h stop=%b, want %02h stop=1",
                                     got, stop_bit, want);
                        end
`ifdef IO_UART_PARITY_EN
                        vectors++;
                        if (par_bit !== ^want) begin
                            miscompares++;
                            $display("FAIL line_parity: byte %02h got %b, want %b",
                                     want, par_bit, ^want);
                        end
`endif
                    end
                end
            end
        end
    end

    task automatic test_reset();
        tick(2);
        vectors++;
        if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_tx: got %b, want 1", tx);
        end
        vectors++;
        if (io_in !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_io_in: got %04h, want 0000", io_in);
        end
        reset = 1'b0;
        tick(3);
        vectors++;
        if (io_in !== 16'h0000 || tx !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: got io_in=%04h tx=%b, want 0000 1", io_in, tx);
        end
    endtask

    // Write one word from idle and check start latency, back-to-back bytes and busy span.
    task automatic test_word_timing(input string name, input logic [15:0] w);
        io_out = w;
        expect_word(w);
        tick(1);  // push edge P
        vectors++;
        if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_tx_before: got %b, want 1", name, tx);
        end
        tick(1);  // P+1
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_tx_fall: got %b, want 0", name, tx);
        end
        vectors++;
        if (io_in[15] !== 1'b1 || io_in[12:10] !== 3'd1) begin
            miscompares++;
            $display("FAIL %s_status_pushed: got busy=%b count=%0d, want 1 1",
                     name, io_in[15], io_in[12:10]);
        end
        tick(WORD_CYC / 2);  // second byte's start bit, no gap
        vectors++;
        if (tx !== 1'b0 || io_in[15] !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_second_start: got tx=%b busy=%b, want 0 1", name, tx, io_in[15]);
        end
        tick(WORD_CYC / 2);  // P+1+WORD_CYC: FSM just returned to idle
        vectors++;
        if (io_in[15] !== 1'b1 || tx !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_busy_last: got busy=%b tx=%b, want 1 1", name, io_in[15], tx);
        end
        tick(1);
        vectors++;
        if (io_in[15] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_busy_clear: got %b, want 0", name, io_in[15]);
        end
        wait_drain(name, 200);
    endtask

    task automatic test_single_word();
        test_word_timing("single", 16'hA55A);
    endtask

    task automatic test_repeated();
        io_out = 16'h1234;
        expect_word(16'h1234);
        tick(3);
        vectors++;
        if (io_in[12:10] !== 3'd0) begin
            miscompares++;
            $display("FAIL repeat_count_popped: got %0d, want 0", io_in[12:10]);
        end
        tick(10);
        io_out = 16'h1234;
        tick(3);
        vectors++;
        if (io_in[12:10] !== 3'd0) begin
            miscompares++;
            $display("FAIL repeat_count_rewrite: got %0d, want 0", io_in[12:10]);
        end
        wait_drain("repeat", 300);
        tick(6);
        vectors++;
        if (io_in[15] !== 1'b0 || tx !== 1'b1) begin
            miscompares++;
            $display("FAIL repeat_no_resend: got busy=%b tx=%b, want 0 1", io_in[15], tx);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] vals [5];
        vals = '{16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        do_reset();
        io_out = 16'h1111;
        expect_word(16'h1111);
        tick(1);  // P
        for (int i = 0; i < 5; i++) begin
            io_out = vals[i];
            if (i < 4) expect_word(vals[i]);
            tick(1);  // sampled at P+1+i
        end
        vectors++;
        if (io_in[14] !== 1'b1 || io_in[13] !== 1'b0 || io_in[12:10] !== 3'd4) begin
            miscompares++;
            $display("FAIL ovf_full: got full=%b ovf=%b count=%0d, want 1 0 4",
                     io_in[14], io_in[13], io_in[12:10]);
        end
        tick(1);
        vectors++;
        if (io_in[13] !== 1'b1 || io_in[12:10] !== 3'd4) begin
            miscompares++;
            $display("FAIL ovf_set: got ovf=%b count=%0d, want 1 4", io_in[13], io_in[12:10]);
        end
        wait_drain("ovf", 1200);
        vectors++;
        if (io_in[13] !== 1'b1 || io_in[14] !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_sticky: got ovf=%b full=%b, want 1 0", io_in[13], io_in[14]);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        io_out = 16'h0F0F;
        expect_word(16'h0F0F);
        tick(1);  // P
        for (int i = 1; i <= 4; i++) begin
            io_out = 16'(i * 16'h1010 + 16'h0101);
            expect_word(io_out);
            tick(1);  // P+i
        end
        tick(77);  // P+81: first word done, FSM idle, FIFO full
        io_out = 16'hBEEF;
        expect_word(16'hBEEF);
        tick(2);  // P+83: status shows state after the P+82 pop/push edge
        vectors++;
        if (io_in[12:10] !== 3'd4 || io_in[14] !== 1'b1 || io_in[13] !== 1'b0) begin
            miscompares++;
            $display("FAIL pushpop_status: got count=%0d full=%b ovf=%b, want 4 1 0",
                     io_in[12:10], io_in[14], io_in[13]);
        end
        wait_drain("pushpop", 1200);
    endtask

    task automatic test_reset_mid_byte();
        int lows = 0;
        do_reset();
        io_out = 16'hC3F0;
        expect_word(16'hC3F0);
        tick(1);   // P
        tick(18);  // inside data bit 3 of 0xF0 (a zero)
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_bit3: got %b, want 0", tx);
        end
        reset = 1'b1;
        exp_q.delete();
        #1;
        vectors++;
        if (tx !== 1'b1 || io_in !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_async: got tx=%b io_in=%04h, want 1 0000", tx, io_in);
        end
        io_out = '0;
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (tx !== 1'b1) lows++;
        end
        vectors++;
        if (lows != 0 || io_in !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_no_residual: got %0d low cycles io_in=%04h, want 0 0000",
                     lows, io_in);
        end
    endtask

`ifdef IO_UART_PARITY_EN
    task automatic test_parity();
        do_reset();
        test_word_timing("parity", 16'h0301);
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_repeated();
        test_overflow();
        test_push_pop();
        test_reset_mid_byte();
`ifdef IO_UART_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule

// File: doc/io_uart_tx_port.md
# io_uart_tx_port

External-side endpoint of the processor's 16-bit I/O interface: consumes the datapath's `ioOut` word and reports status back through `ioIn`. Every new value on `ioOut` is queued in a small FIFO and sent over a single-wire UART line as two bytes, low byte first. The block gives the processor a polled serial-output port with no extra control wiring.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Must be ≥2.
- `FIFO_DEPTH`, 4: word FIFO entries. Must be a power of two, ≤4.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `io_out` in 16: connects to the datapath `ioOut`.
- `io_in` out 16: status word to the datapath `ioIn`.
- `tx` out 1: serial line, idle high.

## Operation
- **Write detection:** register `last` (reset 0). On each edge where `io_out != last`:
  - `last <= io_out`.
  - Push `io_out` to the FIFO.
- **Repeated values:** writing the same value twice in a row sends it once. This is the defined behaviour.
- **Overflow:** a push while the FIFO is full and no pop occurs that edge drops the word and sets the sticky `overflow` bit. Only reset clears `overflow`.
- **Push and pop on the same edge:** both take effect, including when the FIFO is full.
- **FIFO:** circular, with read/write pointers and a count. Pointers wrap at `FIFO_DEPTH`. No bypass: a word pushed into an empty FIFO is popped on the next edge at the earliest.
- **FSM states:** IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE: if the FIFO is non-empty, pop a word into a 16-bit holding register, set `byte_sel=0`, go to START. Otherwise stay in IDLE.
  - START: `tx=0` for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: 8 bits, LSB first, taken from the selected byte; `CLKS_PER_BIT` cycles each. Then PARITY or STOP.
  - STOP: `tx=1` for `CLKS_PER_BIT` cycles. Then:
    - if `byte_sel=0`: set `byte_sel=1` and go to START (no idle gap);
    - otherwise go to IDLE.
- **`io_in` bits:**
  - [15] `busy`: FIFO non-empty or FSM not in IDLE.
  - [14] `full`.
  - [13] `overflow`.
  - [12:10] FIFO count.
  - [9:0] always 0.
- **Reset values:** `tx=1`, `io_in=16'h0000`, FIFO empty, FSM in IDLE, `last=0`, `overflow=0`.

## Timing
- `io_out` change sampled at edge N, pushed at edge N.
- Pop at edge N+1 when the FIFO was empty and the FSM idle; `tx` falls after edge N+1.
- **Frame length:** 10·`CLKS_PER_BIT` cycles per byte (11 with parity). One word is 20 (22) bit times back-to-back.
- **Back-to-back words:** one extra IDLE cycle between words, when the FSM passes through IDLE to pop.
- `io_in` is registered and reflects FIFO/FSM state one cycle after the causing edge.
- **Reset mid-frame:** `tx` returns high asynchronously; the queued and in-flight words are discarded.
- **Bit counter:** a `$clog2(CLKS_PER_BIT)`-bit down-counter reloads at every state or bit change.

## Configuration
- **`IO_UART_PARITY_EN` defined:** the PARITY state is compiled in. It sends an even-parity bit (XOR of the 8 data bits) after DATA, for `CLKS_PER_BIT` cycles. Frame is 8E1.
- **Macro undefined:** no PARITY state; DATA goes directly to STOP. Frame is 8N1.

## Structure
- **Package `io_uart_pkg`:** FSM state enum, `IO_IN` bit-position constants, and frame-length constants (`BITS_PER_FRAME` for the parity and no-parity variants).
- **Sub-module `uart_tx_byte`:** the START/DATA/PARITY/STOP shifter with a byte/valid/ready handshake.
- **Top level:** write detection, FIFO, two-byte sequencing and the status word.

## Test plan
All scenarios use `CLKS_PER_BIT=4`.
- **Single word:** `io_out` 0→16'hA55A.
  - `tx` falls 1 cycle after the push edge.
  - Bytes decode as 0x5A then 0xA5, 80 cycles total.
  - `io_in[15]` is 1 during transmission and 0 afterwards.
- **Repeated value:** hold 16'h1234, then rewrite 16'h1234 → only one word is sent; FIFO count stays 0 after the pop.
- **Overflow:** while the first word is in flight, apply 5 distinct values.
  - `io_in[14]=1` once the FIFO is full.
  - `io_in[13]=1` after the 5th value (dropped) and stays 1.
  - Only the first 5 words appear on `tx`.
- **Push and pop together:** with the FIFO full and the FSM entering IDLE, a change on `io_out` → pushed; count stays 4; `overflow` remains 0.
- **Reset mid-byte:** assert `reset` during DATA bit 3.
  - `tx=1` and `io_in=0` immediately.
  - After release, no residual bits are sent.
- **Parity (`IO_UART_PARITY_EN` defined):** 16'h0301 → byte 0x01 parity 1, byte 0x03 parity 0; 88 cycles total.
